// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: IDLE/FETCH/DECODE/EXEC over one ready-handshaked memory port.
// Optional build macro ACC_CPU_JZ_EN turns op=11 from JMP into JZ (jump only when zero=1).
module acc_cpu_core #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-3:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-3:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-3:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] ir,
    output logic              zero,
    output logic              carry,
    output logic              instr_done,
    output logic [1:0]        state
);
    localparam int ADDR_W = DATA_W - 2;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_STA = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        EXEC   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op;
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W:0]     sum;
    logic                retire;

    assign op        = ir[DATA_W-1:DATA_W-2];
    assign adr       = ir[ADDR_W-1:0];
    assign sum       = {1'b0, ac} + {1'b0, mem_rdata};
    assign mem_wdata = ac;
    assign state     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Requests are pure decodes of state/ir, so they stay stable until the ready edge.
    always_comb begin
        state_d  = state_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        retire   = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                if (op == OP_JMP) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                mem_addr = adr;
                mem_rd   = (op != OP_STA);
                mem_wr   = (op == OP_STA);
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ac         <= '0;
            ir         <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            instr_done <= retire;
            case (state_q)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                DECODE: begin
`ifdef ACC_CPU_JZ_EN
                    if (op == OP_JMP && zero) pc <= adr;
`else
                    if (op == OP_JMP) pc <= adr;
`endif
                end
                EXEC: begin
                    if (mem_ready) begin
                        case (op)
                            OP_LDA: begin
                                ac   <= mem_rdata;
                                zero <= (mem_rdata == '0);
                            end
                            OP_ADD: begin
                                {carry, ac} <= sum;
                                zero        <= (sum[DATA_W-1:0] == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench: an instruction-level ISA model predicts retire state and stores;
// a randomized wait-state memory responder serves the DUT and a monitor checks retires.
module tb_acc_cpu_core;
    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] pc;
    logic [DW-1:0] ac, ir;
    logic          zero, carry, instr_done;
    logic [1:0]    state;

    always #5 clk = ~clk;

    acc_cpu_core #(.DATA_W(DW), .RESET_PC(6'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .ac(ac), .ir(ir), .zero(zero), .carry(carry),
        .instr_done(instr_done), .state(state)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] ac;
        logic          zero;
        logic          carry;
        logic [DW-1:0] ir;
    } retire_t;
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    retire_t       exp_q[$];
    wr_t           wr_q[$];
    logic [DW-1:0] mem  [64];
    logic [DW-1:0] mmem [64];

    int errors = 0;
    int checks = 0;
    int wait_mode = 0;
    bit stall = 1'b0;
    int wait_acc = 0;

    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ac;
    logic          m_zero, m_carry;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequential ISA interpreter on a private copy of memory.
    task automatic model_run(input int n);
        logic [DW-1:0] instr;
        logic [AW-1:0] a;
        int            s;
        for (int i = 0; i < n; i++) begin
            instr = mmem[m_pc];
            a     = instr[AW-1:0];
            m_pc  = AW'((int'(m_pc) + 1) % 64);
            case (instr[7:6])
                2'd0: begin m_ac = mmem[a]; m_zero = (m_ac == 0); end
                2'd1: begin mmem[a] = m_ac; wr_q.push_back('{a: a, d: m_ac}); end
                2'd2: begin
                    s       = int'(m_ac) + int'(mmem[a]);
                    m_carry = (s > 255);
                    m_ac    = DW'(s % 256);
                    m_zero  = (m_ac == 0);
                end
                default: begin
`ifdef ACC_CPU_JZ_EN
                    if (m_zero) m_pc = a;
`else
                    m_pc = a;
`endif
                end
            endcase
            exp_q.push_back('{pc: m_pc, ac: m_ac, zero: m_zero, carry: m_carry, ir: instr});
        end
    endtask

    // Monitor: checks architectural state and cycle count at every retire pulse.
    initial begin
        int      cyc, last, base;
        bit      first;
        retire_t e;
        cyc = 0; last = 0; first = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                first = 1'b1;
            end else begin
                if (first && state == 2'd1) begin
                    first = 1'b0; last = cyc; wait_acc = 0;
                end
                if (instr_done) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_retire actual=1 expected=0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("retire_ir", ir, e.ir);
                        chk("retire_pc", pc, e.pc);
                        chk("retire_ac", ac, e.ac);
                        chk("retire_zero", zero, e.zero);
                        chk("retire_carry", carry, e.carry);
                        base = (e.ir[7:6] == 2'd3) ? 2 : 3;
                        chk("latency", cyc - last, base + wait_acc);
                    end
                    last = cyc; wait_acc = 0;
                end
            end
        end
    end

    // Memory responder with per-request wait states; also checks request stability and stores.
    initial begin
        int            cnt, tgt;
        bit            pend;
        logic          s_rd, s_wr;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        wr_t           w;
        cnt = 0; tgt = 0; pend = 1'b0;
        s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                mem_ready = 1'b0; cnt = 0; pend = 1'b0;
                tgt = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
            end else if (mem_rd || mem_wr) begin
                if (pend) begin
                    chk("hold_rd", mem_rd, s_rd);
                    chk("hold_wr", mem_wr, s_wr);
                    chk("hold_addr", mem_addr, s_addr);
                    chk("hold_wdata", mem_wdata, s_wdata);
                end
                chk("rd_wr_exclusive", mem_rd & mem_wr, 1'b0);
                if (!stall && cnt >= tgt) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_rd ? mem[mem_addr] : DW'($urandom);
                    if (mem_wr) begin
                        if (wr_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_store actual=%0h expected=none", mem_addr);
                        end else begin
                            w = wr_q.pop_front();
                            chk("store_addr", mem_addr, w.a);
                            chk("store_data", mem_wdata, w.d);
                        end
                        mem[mem_addr] = mem_wdata;
                    end
                    cnt = 0; pend = 1'b0;
                    tgt = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = DW'($urandom);
                    cnt++; wait_acc++; pend = 1'b1;
                    s_rd = mem_rd; s_wr = mem_wr; s_addr = mem_addr; s_wdata = mem_wdata;
                end
            end else begin
                mem_ready = 1'(($urandom_range(0, 1)));
                mem_rdata = DW'($urandom);
                pend = 1'b0;
            end
        end
    end

    task automatic load_directed();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 8'h0A; mem[1] = 8'h8B; mem[2] = 8'h4C; mem[3] = 8'hC0;
        mem[10] = 8'h05; mem[11] = 8'hFE;
    endtask

    task automatic run_prog(input int n, input int wm);
        int i;
        wait_mode = wm;
        rst_n = 1'b0;
        mmem = mem;
        m_pc = '0; m_ac = '0; m_zero = 1'b0; m_carry = 1'b0;
        model_run(n);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("idle_after_release", state, 2'd0);
        chk("no_req_in_idle", mem_rd, 1'b0);
        @(negedge clk);
        chk("first_fetch_state", state, 2'd1);
        chk("first_fetch_rd", mem_rd, 1'b1);
        chk("first_fetch_addr", mem_addr, 6'd0);
        for (i = 0; i < 4000 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL retire_timeout actual=%0d expected=0 pending", exp_q.size());
            exp_q.delete();
        end
        chk("stores_drained", wr_q.size(), 0);
        wr_q.delete();
        rst_n = 1'b0;
    endtask

    initial begin
        // Async reset in the middle of a stalled fetch.
        load_directed();
        stall = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("stalled_fetch_rd", mem_rd, 1'b1);
        chk("stalled_fetch_state", state, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 6'd0);
        chk("rst_ac", ac, 8'd0);
        chk("rst_ir", ir, 8'd0);
        chk("rst_state", state, 2'd0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_addr", mem_addr, 6'd0);
        chk("rst_flags", {zero, carry, instr_done}, 3'b000);
        stall = 1'b0;

        // Test-plan program, zero then three wait states per request.
        run_prog(8, 0);
        chk("mem12_stored", mem[12], 8'h03);
        load_directed();
        run_prog(4, 3);

        // Zero flag, carry-out to zero, jump to top address and pc wrap.
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 8'h0A; mem[1] = 8'h8A; mem[2] = 8'h0B; mem[3] = 8'hFF;
        mem[63] = 8'h0C; mem[10] = 8'h80; mem[11] = 8'h00; mem[12] = 8'h11;
        run_prog(8, 0);

        // Random programs with random wait states.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
            run_prog(25, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
